// File: rtl/viterbi_chan_sched.sv
// viterbi_chan_sched
// Time-shares one Viterbi decode pipeline among NCH requester channels.
// Each granted frame is streamed word by word, followed by FLUSH_WORDS zero
// words that push the trellis through. Decoded bytes are tagged with the
// owning channel, and bytes produced by the flush words are dropped.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (channel 0 first)
// instead of the default round-robin arbitration.
module viterbi_chan_sched #(
  parameter int NCH         = 4,
  parameter int CW          = 2,
  parameter int MAX_WORDS   = 64,
  parameter int FLUSH_WORDS = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req_valid_i,
  input  logic [NCH*16-1:0] req_data_i,
  input  logic [NCH-1:0]    req_last_i,
  output logic [NCH-1:0]    req_ready_o,
  output logic              core_valid_o,
  output logic [15:0]       core_data_o,
  input  logic              core_ready_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic [7:0]        out_data_o,
  output logic              out_valid_o,
  output logic [CW-1:0]     out_chan_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              err_timeout_o
);

  localparam int WW = $clog2(MAX_WORDS + 1);
  localparam int BW = $clog2(MAX_WORDS + FLUSH_WORDS + 1) + 1;
  localparam int FW = $clog2(FLUSH_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [WW-1:0] LAST_WORD_IDX  = WW'(MAX_WORDS - 1);
  localparam logic [FW-1:0] LAST_FLUSH_IDX = FW'(FLUSH_WORDS - 1);
  localparam logic [TW-1:0] TMO_LAST       = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] FLUSH_B        = BW'(FLUSH_WORDS);
  localparam logic [CW-1:0] LAST_CH        = CW'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_SEND,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic [WW-1:0] data_words_q, data_words_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_chan_q, out_chan_d;
  logic          out_last_q, out_last_d;
  logic          err_q, err_d;

  logic [15:0]   ch_word [NCH];
  logic [CW-1:0] arb_idx;
  logic          arb_hit;
  logic          xfer;
  logic          go_flush;
  logic          in_frame;
  logic          len_known;
  logic [BW-1:0] dw_b;
  logic          byte_keep;
  logic          byte_last;

  for (genvar g = 0; g < NCH; g++) begin : g_split
    assign ch_word[g] = req_data_i[16*g +: 16];
  end

  // Arbiter: first valid channel searching upward from rr_ptr (or from 0).
  always_comb begin
    int          c;
    logic [CW-1:0] cidx;
    arb_idx = '0;
    arb_hit = 1'b0;
    c       = 0;
    cidx    = '0;
    for (int i = 0; i < NCH; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      c = i;
`else
      c = (int'(rr_ptr_q) + i) % NCH;
`endif
      cidx = CW'(c);
      if (!arb_hit && req_valid_i[cidx]) begin
        arb_hit = 1'b1;
        arb_idx = cidx;
      end
    end
  end

  // Word handshake towards the pipeline: pass-through in SEND, zeros in FLUSH.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    core_valid_o = 1'b0;
    core_data_o  = '0;
    req_ready_o  = '0;
    case (state_q)
      S_SEND: begin
        core_valid_o         = req_valid_i[grant_q];
        core_data_o          = ch_word[grant_q];
        req_ready_o[grant_q] = core_ready_i;
      end
      S_FLUSH: core_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign xfer      = core_valid_o & core_ready_i;
  assign go_flush  = (state_q == S_SEND) && xfer &&
                     (req_last_i[grant_q] || (word_cnt_q == LAST_WORD_IDX));
  assign in_frame  = (state_q == S_SEND) || (state_q == S_FLUSH) || (state_q == S_DRAIN);
  // While still sending, the frame length is only known on the closing transfer;
  // until then every byte necessarily belongs to an already-sent data word.
  assign len_known = (state_q != S_SEND) || go_flush;
  assign dw_b      = go_flush ? BW'(word_cnt_q) + BW'(1) : BW'(data_words_q);
  assign byte_keep = !len_known || (byte_cnt_q < dw_b);
  assign byte_last = len_known && (byte_cnt_q == dw_b - BW'(1));

  // Next-state, counters and tagged-byte output computation.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    word_cnt_d   = word_cnt_q;
    data_words_d = data_words_q;
    flush_cnt_d  = flush_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = err_q;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;

    // A strobe is counted in every frame state, including on a state change.
    if (byte_valid_i && in_frame) begin
      byte_cnt_d = byte_cnt_q + BW'(1);
      if (byte_keep) begin
        out_valid_d = 1'b1;
        out_last_d  = byte_last;
        out_data_d  = byte_i;
        out_chan_d  = grant_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|req_valid_i) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_hit) begin
          grant_d    = arb_idx;
`ifdef ARB_FIXED_PRIO_EN
          rr_ptr_d   = '0;
`else
          rr_ptr_d   = (arb_idx == LAST_CH) ? '0 : arb_idx + CW'(1);
`endif
          word_cnt_d = '0;
          byte_cnt_d = '0;
          state_d    = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (xfer) word_cnt_d = word_cnt_q + WW'(1);
        if (go_flush) begin
          data_words_d = word_cnt_q + WW'(1);
          flush_cnt_d  = '0;
          state_d      = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (xfer) begin
          flush_cnt_d = flush_cnt_q + FW'(1);
          if (flush_cnt_q == LAST_FLUSH_IDX) begin
            tmo_cnt_d = '0;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (byte_cnt_q >= BW'(data_words_q) + FLUSH_B) begin
          state_d = S_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      word_cnt_q   <= '0;
      data_words_q <= '0;
      flush_cnt_q  <= '0;
      byte_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_chan_q   <= '0;
      out_last_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      word_cnt_q   <= word_cnt_d;
      data_words_q <= data_words_d;
      flush_cnt_q  <= flush_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_chan_q   <= out_chan_d;
      out_last_q   <= out_last_d;
      err_q        <= err_d;
    end
  end

  assign out_data_o    = out_data_q;
  assign out_valid_o   = out_valid_q;
  assign out_chan_o    = out_chan_q;
  assign out_last_o    = out_last_q;
  assign err_timeout_o = err_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_viterbi_chan_sched.sv
// Self-checking bench for viterbi_chan_sched: per-channel word sources, a
// latency pipeline model returning one byte per accepted word, and
// scoreboards for core words and tagged output bytes.
module tb_viterbi_chan_sched;

  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    req_valid_i = '0;
  logic [NCH*16-1:0] req_data_i;
  logic [NCH-1:0]    req_last_i = '0;
  logic [NCH-1:0]    req_ready_o;
  logic              core_valid_o;
  logic [15:0]       core_data_o;
  logic              core_ready_i = 1'b1;
  logic [7:0]        byte_i = '0;
  logic              byte_valid_i = 1'b0;
  logic [7:0]        out_data_o;
  logic              out_valid_o;
  logic [CW-1:0]     out_chan_o;
  logic              out_last_o;
  logic              busy_o;
  logic              err_timeout_o;

  logic [15:0] tb_word [NCH];
  assign req_data_i = {tb_word[3], tb_word[2], tb_word[1], tb_word[0]};

  viterbi_chan_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_data_i    (req_data_i),
    .req_last_i    (req_last_i),
    .req_ready_o   (req_ready_o),
    .core_valid_o  (core_valid_o),
    .core_data_o   (core_data_o),
    .core_ready_i  (core_ready_i),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .out_chan_o    (out_chan_o),
    .out_last_o    (out_last_o),
    .busy_o        (busy_o),
    .err_timeout_o (err_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    b;
    logic [CW-1:0] ch;
    logic          last;
  } exp_byte_t;

  typedef struct {
    logic [7:0] b;
    int         due;
  } pipe_t;

  typedef struct {
    int ch;
    int nwords;
    bit toggle;
    int exp_bytes;
    int exp_xfers;
    int exp_lasts;
  } vec_t;

  exp_byte_t   exp_bytes[$];
  logic [15:0] exp_words[$];
  pipe_t       pipe[$];
  logic [16:0] src_q [NCH][$];
  int          grant_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fidx = 0;
  int model_idx = 0;
  int out_cnt = 0;
  int last_cnt = 0;
  int xfer_cnt = 0;
  int busy_cycles = 0;
  bit hold_bytes = 1'b0;
  bit toggle_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input int ch, input int i);
    if (i < 3) return 16'((i + 1) * 16'h1111 + ch * 16'h0100);
    return {8'(i * 7 + ch), 8'(i * 13 + 5)};
  endfunction

  function automatic bit srcs_empty();
    for (int k = 0; k < NCH; k++) if (src_q[k].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load_frame(input int ch, input int n);
    for (int i = 0; i < n; i++) src_q[ch].push_back({(i == n - 1), word_of(ch, i)});
  endtask

  task automatic clear_bench();
    for (int k = 0; k < NCH; k++) src_q[k].delete();
    exp_bytes.delete();
    exp_words.delete();
    pipe.delete();
    fidx = 0;
    model_idx = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy_o && srcs_empty() && (hold_bytes || pipe.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done"}, 32'(ok), 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Source driver: present each channel's head word just after the clock edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NCH; k++) begin
      if (src_q[k].size() > 0) begin
        req_valid_i[k] = 1'b1;
        tb_word[k]     = src_q[k][0][15:0];
        req_last_i[k]  = src_q[k][0][16];
      end else begin
        req_valid_i[k] = 1'b0;
        tb_word[k]     = 16'h0000;
        req_last_i[k]  = 1'b0;
      end
    end
    core_ready_i = toggle_ready ? ~core_ready_i : 1'b1;
  end

  // Monitors and pipeline model, all sampled on the falling edge.
  always @(negedge clk) begin
    logic [15:0] w;
    logic        endf;
    logic [7:0]  eb;
    logic [15:0] ew;
    exp_byte_t   e;
    if (rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        if (req_valid_i[k] && req_ready_o[k]) begin
          w    = tb_word[k];
          endf = req_last_i[k] || (fidx == 63);
          eb   = w[7:0] ^ w[15:8] ^ (8'hA0 + 8'(fidx));
          exp_bytes.push_back('{b: eb, ch: CW'(k), last: endf});
          exp_words.push_back(w);
          if (fidx == 0) grant_log.push_back(k);
          if (endf) begin
            repeat (3) exp_words.push_back(16'h0000);
            fidx = 0;
          end else begin
            fidx++;
          end
          if (src_q[k].size() > 0) void'(src_q[k].pop_front());
        end
      end
      if (!busy_o) model_idx = 0;
      if (core_valid_o && core_ready_i) begin
        xfer_cnt++;
        if (exp_words.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL core_word: got 0x%0h required no transfer", core_data_o);
        end else begin
          ew = exp_words.pop_front();
          check("core_word", 32'(core_data_o), 32'(ew));
        end
        pipe.push_back('{b: core_data_o[7:0] ^ core_data_o[15:8] ^ (8'hA0 + 8'(model_idx)),
                         due: cyc + LAT});
        model_idx++;
      end
      if (out_valid_o) begin
        out_cnt++;
        if (out_last_o) last_cnt++;
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_byte: got 0x%0h required no output", out_data_o);
        end else begin
          e = exp_bytes.pop_front();
          check("out_byte", 32'(out_data_o), 32'(e.b));
          check("out_chan", 32'(out_chan_o), 32'(e.ch));
          check("out_last", 32'(out_last_o), 32'(e.last));
        end
      end
      if (busy_o) busy_cycles++;
    end
    if (!hold_bytes && pipe.size() > 0 && pipe[0].due <= cyc) begin
      byte_valid_i = 1'b1;
      byte_i       = pipe[0].b;
      void'(pipe.pop_front());
    end else begin
      byte_valid_i = 1'b0;
      byte_i       = 8'h00;
    end
  end

  vec_t vecs[5];
  int   exp_g[4];

  initial begin
    vecs[0] = '{ch: 0, nwords: 3,  toggle: 1'b0, exp_bytes: 3,  exp_xfers: 6,  exp_lasts: 1};
    vecs[1] = '{ch: 1, nwords: 1,  toggle: 1'b0, exp_bytes: 1,  exp_xfers: 4,  exp_lasts: 1};
    vecs[2] = '{ch: 3, nwords: 5,  toggle: 1'b1, exp_bytes: 5,  exp_xfers: 8,  exp_lasts: 1};
    vecs[3] = '{ch: 2, nwords: 2,  toggle: 1'b1, exp_bytes: 2,  exp_xfers: 5,  exp_lasts: 1};
    vecs[4] = '{ch: 2, nwords: 70, toggle: 1'b0, exp_bytes: 70, exp_xfers: 76, exp_lasts: 2};
`ifdef ARB_FIXED_PRIO_EN
    exp_g = '{1, 1, 1, 1};
`else
    exp_g = '{1, 3, 1, 3};
`endif
    for (int k = 0; k < NCH; k++) tb_word[k] = 16'h0000;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",       32'(busy_o),        32'd0);
    check("rst_err",        32'(err_timeout_o), 32'd0);
    check("rst_out_valid",  32'(out_valid_o),   32'd0);
    check("rst_out_data",   32'(out_data_o),    32'd0);
    check("rst_out_last",   32'(out_last_o),    32'd0);
    check("rst_core_valid", 32'(core_valid_o),  32'd0);
    check("rst_req_ready",  32'(req_ready_o),   32'd0);
    rst_n = 1'b1;

    // Frame vectors.
    for (int v = 0; v < 5; v++) begin
      @(posedge clk);
      #2;
      out_cnt      = 0;
      last_cnt     = 0;
      xfer_cnt     = 0;
      toggle_ready = vecs[v].toggle;
      load_frame(vecs[v].ch, vecs[v].nwords);
      wait_done($sformatf("vec%0d", v), 1500);
      check($sformatf("vec%0d_bytes", v), 32'(out_cnt),  32'(vecs[v].exp_bytes));
      check($sformatf("vec%0d_xfers", v), 32'(xfer_cnt), 32'(vecs[v].exp_xfers));
      check($sformatf("vec%0d_lasts", v), 32'(last_cnt), 32'(vecs[v].exp_lasts));
      check($sformatf("vec%0d_busy", v),  32'(busy_o),   32'd0);
      check($sformatf("vec%0d_left", v),  32'(exp_bytes.size() + exp_words.size()), 32'd0);
      toggle_ready = 1'b0;
    end

    // Drain timeout with bytes withheld.
    @(posedge clk);
    #2;
    check("tmo_err_before", 32'(err_timeout_o), 32'd0);
    busy_cycles = 0;
    out_cnt     = 0;
    hold_bytes  = 1'b1;
    load_frame(0, 2);
    wait_done("tmo", 1000);
    check("tmo_err",      32'(err_timeout_o), 32'd1);
    check("tmo_duration", 32'(busy_cycles >= 255 && busy_cycles <= 285), 32'd1);
    check("tmo_no_bytes", 32'(out_cnt), 32'd0);
    check("tmo_withheld", 32'(exp_bytes.size()), 32'd2);
    exp_bytes.delete();
    pipe.delete();
    hold_bytes = 1'b0;

    // Sticky error survives a normal frame.
    @(posedge clk);
    #2;
    out_cnt = 0;
    load_frame(3, 1);
    wait_done("sticky", 200);
    check("sticky_err",   32'(err_timeout_o), 32'd1);
    check("sticky_bytes", 32'(out_cnt), 32'd1);

    // Reset in the middle of SEND.
    @(posedge clk);
    #2;
    out_cnt = 0;
    load_frame(1, 10);
    for (int n = 0; n < 100 && out_cnt == 0; n++) @(negedge clk);
    check("mid_saw_byte", 32'(out_cnt > 0), 32'd1);
    @(posedge clk);
    #2;
    check("mid_pre_busy",       32'(busy_o),       32'd1);
    check("mid_pre_core_valid", 32'(core_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy",       32'(busy_o),        32'd0);
    check("mid_core_valid", 32'(core_valid_o),  32'd0);
    check("mid_req_ready",  32'(req_ready_o),   32'd0);
    check("mid_out_valid",  32'(out_valid_o),   32'd0);
    check("mid_out_data",   32'(out_data_o),    32'd0);
    check("mid_out_chan",   32'(out_chan_o),    32'd0);
    check("mid_out_last",   32'(out_last_o),    32'd0);
    check("mid_err",        32'(err_timeout_o), 32'd0);
    clear_bench();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Two channels continuously valid with one-word frames.
    @(posedge clk);
    #2;
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      src_q[1].push_back({1'b1, word_of(1, i)});
      src_q[3].push_back({1'b1, word_of(3, i)});
    end
    wait_done("rr", 2000);
    check("rr_frames", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) check($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(exp_g[i]));
      else check($sformatf("rr_grant%0d", i), 32'hFFFF_FFFF, 32'(exp_g[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
